// File: rtl/feature_collector_pkg.sv
// Shared types and address-field constants for the feature collector.
package feature_collector_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int ROW_MSB    = 15;
  localparam int ROW_LSB    = 8;
  localparam int COL_MSB    = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/feature_collector_if.sv
// Upstream decision stream and downstream feature stream of the collector.
interface feature_collector_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  in_isfeature;
  logic [ADDR_WIDTH-1:0] in_feature_addr;
  logic                  in_feature_valid;
  logic                  ready_for_new_feature;

  logic                  out_feature_valid;
  logic [ADDR_WIDTH-1:0] out_feature_addr;
  logic [7:0]            out_feature_row;
  logic [7:0]            out_feature_col;
  logic                  in_feature_req;

  // slave is the collector; master is the NMS stage plus the host reader
  modport slave (
    input  in_isfeature, in_feature_addr, in_feature_valid, in_feature_req,
    output ready_for_new_feature, out_feature_valid, out_feature_addr,
           out_feature_row, out_feature_col
  );

  modport master (
    output in_isfeature, in_feature_addr, in_feature_valid, in_feature_req,
    input  ready_for_new_feature, out_feature_valid, out_feature_addr,
           out_feature_row, out_feature_col
  );

endinterface

// File: rtl/feature_fifo.sv
// First-word fall-through FIFO; an extra pointer bit separates full from empty.
module feature_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // Forcing zero while empty keeps the head clean after reset and between frames.
  assign dout  = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/feature_collector.sv
// Terminal sink of the corner pipeline: buffers detected features and keeps per-frame statistics.
module feature_collector #(
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = feature_collector_pkg::ADDR_WIDTH,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   frame_end,
  feature_collector_if.slave     bus,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic [COUNT_WIDTH-1:0] feature_count,
  output logic                   busy,
  output logic                   frame_done
);

  import feature_collector_pkg::*;

  state_t                state;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  ready;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] head;

  // Ready depends only on registered state and occupancy, never on the incoming valid.
  assign ready  = (state == COLLECT) && !fifo_full;
  assign accept = bus.in_feature_valid & ready;
  assign push   = accept & bus.in_isfeature;
  assign pop    = !fifo_empty & bus.in_feature_req;

  feature_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_feature_addr),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.ready_for_new_feature = ready;
  assign bus.out_feature_valid     = !fifo_empty;
  assign bus.out_feature_addr      = head;
  assign bus.out_feature_row       = head[ROW_MSB:ROW_LSB];
  assign bus.out_feature_col       = head[COL_MSB:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= COLLECT;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (frame_end) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Counters saturate and hold across IDLE so the host can read them after the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count   <= '0;
      feature_count <= '0;
    end else if (state == IDLE && start) begin
      event_count   <= '0;
      feature_count <= '0;
    end else if (accept) begin
      if (event_count != '1) event_count <= event_count + 1'b1;
      if (bus.in_isfeature && feature_count != '1) feature_count <= feature_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_feature_collector.sv
// Scoreboard bench: feature addresses queue up when accepted and are compared when popped.
module tb_feature_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        frame_end = 1'b0;
  logic [23:0] event_count;
  logic [23:0] feature_count;
  logic        busy;
  logic        frame_done;

  logic        start2 = 1'b0;
  logic        frame_end2 = 1'b0;
  logic [3:0]  event_count2;
  logic [3:0]  feature_count2;
  logic        busy2;
  logic        frame_done2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_addr;

  feature_collector_if #(.ADDR_WIDTH(16)) bus ();
  feature_collector_if #(.ADDR_WIDTH(16)) bus2 ();

  feature_collector #(.FIFO_DEPTH(16), .ADDR_WIDTH(16), .COUNT_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_end(frame_end), .bus(bus),
    .event_count(event_count), .feature_count(feature_count),
    .busy(busy), .frame_done(frame_done)
  );

  feature_collector #(.FIFO_DEPTH(4), .ADDR_WIDTH(16), .COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .frame_end(frame_end2), .bus(bus2),
    .event_count(event_count2), .feature_count(feature_count2),
    .busy(busy2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bus.in_feature_req = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    tick();
    check(tag, exp_q.size(), 0);
    check({tag, "_empty"}, bus.out_feature_valid, 1'b0);
  endtask

  // Monitor on the falling edge: pops are compared against the queue head, then accepts are queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_feature_valid && bus.in_feature_req) begin
        check("pop_avail", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_addr = exp_q.pop_front();
          check("pop_addr", bus.out_feature_addr, exp_addr);
          check("pop_row", bus.out_feature_row, exp_addr[15:8]);
          check("pop_col", bus.out_feature_col, exp_addr[7:0]);
        end
      end
      if (bus.in_feature_valid && bus.ready_for_new_feature && bus.in_isfeature)
        exp_q.push_back(bus.in_feature_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pattern;
    int         pulses;
    pattern = 5'b01101;  // bit i is isfeature for address 0x0101+i

    bus.in_isfeature = 1'b0;  bus.in_feature_addr = '0;
    bus.in_feature_valid = 1'b0; bus.in_feature_req = 1'b0;
    bus2.in_isfeature = 1'b0; bus2.in_feature_addr = '0;
    bus2.in_feature_valid = 1'b0; bus2.in_feature_req = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_ready", bus.ready_for_new_feature, 1'b0);
    check("rst_out_valid", bus.out_feature_valid, 1'b0);
    check("rst_out_addr", bus.out_feature_addr, 16'h0000);
    check("rst_event", event_count, 24'd0);
    check("rst_feature", feature_count, 24'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    rst = 1'b0;
    tick();

    // frame_end in IDLE is ignored
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("idle_fe_busy", busy, 1'b0);
    tick();
    check("idle_fe_done", frame_done, 1'b0);
    check("idle_ready", bus.ready_for_new_feature, 1'b0);

    // Mixed decisions: only features are queued
    start = 1'b1; tick(); start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_ready", bus.ready_for_new_feature, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_feature_valid = 1'b1;
      bus.in_isfeature = pattern[i];
      bus.in_feature_addr = 16'h0101 + 16'(i);
      tick();
      if (i == 0) begin
        check("lat_valid", bus.out_feature_valid, 1'b1);
        check("lat_addr", bus.out_feature_addr, 16'h0101);
      end
    end
    bus.in_feature_valid = 1'b0;
    check("t1_event", event_count, 24'd5);
    check("t1_feature", feature_count, 24'd3);
    check("t1_queued", exp_q.size(), 3);
    drain("t1_drain");

    // Fill to full with the reader stalled
    bus.in_feature_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_feature_valid = 1'b1;
      bus.in_isfeature = 1'b1;
      bus.in_feature_addr = 16'h0200 + 16'(i);
      tick();
      check("full_ready", bus.ready_for_new_feature, i < 15);
    end
    bus.in_feature_addr = 16'h0210;
    tick(); tick(); tick();
    check("held_ready", bus.ready_for_new_feature, 1'b0);
    check("held_event", event_count, 24'd21);
    bus.in_feature_req = 1'b1;
    tick();
    bus.in_feature_req = 1'b0;
    check("pop_ready", bus.ready_for_new_feature, 1'b1);
    tick();
    bus.in_feature_valid = 1'b0;
    check("t2_event", event_count, 24'd22);
    check("refull_ready", bus.ready_for_new_feature, 1'b0);
    drain("t2_drain");

    // Simultaneous push and pop at occupancy 1
    bus.in_feature_req = 1'b0;
    bus.in_feature_valid = 1'b1;
    bus.in_isfeature = 1'b1;
    bus.in_feature_addr = 16'h0300;
    tick();
    bus.in_feature_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_feature_addr = 16'h0300 + 16'(i);
      tick();
      check("pp_valid", bus.out_feature_valid, 1'b1);
      check("pp_head", bus.out_feature_addr, 16'h0300 + 16'(i));
    end
    bus.in_feature_valid = 1'b0;
    tick();
    check("pp_empty", bus.out_feature_valid, 1'b0);

    // frame_end with three entries queued and the reader ready
    bus.in_feature_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.in_feature_valid = 1'b1;
      bus.in_isfeature = 1'b1;
      bus.in_feature_addr = 16'h0400 + 16'(i);
      tick();
    end
    bus.in_feature_valid = 1'b0;
    bus.in_feature_req = 1'b1;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("fe_ready", bus.ready_for_new_feature, 1'b0);
    check("fe_busy", busy, 1'b1);
    check("fe_done0", frame_done, 1'b0);
    tick(); check("fe_done1", frame_done, 1'b0);
    tick(); check("fe_done2", frame_done, 1'b0);
    check("fe_drained", exp_q.size(), 0);
    tick();
    check("fe_done3", frame_done, 1'b1);
    check("fe_busy_done", busy, 1'b0);
    tick();
    check("fe_done4", frame_done, 1'b0);
    check("fe_idle_ready", bus.ready_for_new_feature, 1'b0);
    check("fe_event", event_count, 24'd36);
    check("fe_feature", feature_count, 24'd34);

    // frame_end in the same cycle as an accept
    start = 1'b1; tick(); start = 1'b0;
    check("clr_event", event_count, 24'd0);
    check("clr_feature", feature_count, 24'd0);
    bus.in_feature_valid = 1'b1;
    bus.in_isfeature = 1'b1;
    bus.in_feature_addr = 16'h0501;
    frame_end = 1'b1;
    tick();
    bus.in_feature_valid = 1'b0;
    frame_end = 1'b0;
    check("fa_event", event_count, 24'd1);
    check("fa_ready", bus.ready_for_new_feature, 1'b0);
    check("fa_valid", bus.out_feature_valid, 1'b1);
    tick(); check("fa_done1", frame_done, 1'b0);
    tick(); check("fa_done2", frame_done, 1'b1);
    tick(); check("fa_done3", frame_done, 1'b0);

    // Empty frame: frame_done one cycle after DRAIN
    start = 1'b1; tick(); start = 1'b0;
    check("ef_busy", busy, 1'b1);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("ef_done0", frame_done, 1'b0);
    check("ef_drain_busy", busy, 1'b1);
    tick();
    check("ef_done1", frame_done, 1'b1);
    check("ef_busy_off", busy, 1'b0);
    tick();
    check("ef_done2", frame_done, 1'b0);
    check("ef_event", event_count, 24'd0);

    // Reset in DRAIN with four entries pending
    start = 1'b1; tick(); start = 1'b0;
    bus.in_feature_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_feature_valid = 1'b1;
      bus.in_isfeature = 1'b1;
      bus.in_feature_addr = 16'h0600 + 16'(i);
      tick();
    end
    bus.in_feature_valid = 1'b0;
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    tick();
    check("rd_busy", busy, 1'b1);
    check("rd_valid", bus.out_feature_valid, 1'b1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("ar_valid", bus.out_feature_valid, 1'b0);
    check("ar_ready", bus.ready_for_new_feature, 1'b0);
    check("ar_event", event_count, 24'd0);
    check("ar_feature", feature_count, 24'd0);
    check("ar_busy", busy, 1'b0);
    pulses = 0;
    for (int k = 0; k < 2; k++) begin tick(); if (frame_done) pulses++; end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); if (frame_done) pulses++; end
    check("ar_no_done", pulses, 0);
    check("ar_still_empty", bus.out_feature_valid, 1'b0);

    // Counter saturation at COUNT_WIDTH=4
    start2 = 1'b1; tick(); start2 = 1'b0;
    bus2.in_feature_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus2.in_feature_valid = 1'b1;
      bus2.in_isfeature = (i < 17);
      bus2.in_feature_addr = 16'h0700 + 16'(i);
      tick();
      if (i == 14) check("sat_at15", event_count2, 4'd15);
    end
    bus2.in_feature_valid = 1'b0;
    check("sat_event", event_count2, 4'd15);
    check("sat_feature", feature_count2, 4'd15);
    check("sat_ready", bus2.ready_for_new_feature, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
